// File: rtl/lbp_hist.sv
// lbp_hist: 256-bin histogram of LBP codes for one IMG_W x IMG_W frame.
// Accumulates in ACCUM, then streams bins 0..255 over valid/ready in DUMP.
// Each bin is cleared as it is read out.
// Build option: define LBP_HIST_SAT_EN to make bins saturate instead of wrap.
module lbp_hist #(
   parameter int BIN_W = 14,
   parameter int IMG_W = 128
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             lbp_valid,
   input  logic [13:0]      lbp_addr,
   input  logic [7:0]       lbp_data,
   input  logic             finish,
   output logic             hist_valid,
   input  logic             hist_ready,
   output logic [7:0]       hist_bin,
   output logic [BIN_W-1:0] hist_count,
   output logic             hist_done,
   output logic [13:0]      pix_cnt,
   output logic             busy,
   output logic             err
);

   typedef enum logic [0:0] {ACCUM = 1'b0, DUMP = 1'b1} state_t;

   state_t           state_r, state_nxt_s;
   logic [BIN_W-1:0] bins_r [256];
   logic [7:0]       rd_idx_r;
   logic [BIN_W-1:0] hist_count_r;
   logic             hist_done_r;
   logic [13:0]      pix_cnt_r;
   logic             err_r;

   logic             accept_s;
   logic             handshake_s;
   logic             last_s;
   logic             border_s;
   logic [13:0]      col_s;
   logic [13:0]      row_s;
   logic [BIN_W-1:0] cur_s;
   logic [BIN_W-1:0] inc_s;
   logic             full_s;
   logic [7:0]       next_idx_s;

   // Sample/handshake qualification and frame-border decode of the pixel address
   always_comb begin
      accept_s    = (state_r == ACCUM) && lbp_valid;
      handshake_s = (state_r == DUMP) && hist_ready;
      last_s      = handshake_s && (rd_idx_r == 8'hFF);
      next_idx_s  = rd_idx_r + 8'd1;
      col_s       = lbp_addr % 14'(IMG_W);
      row_s       = lbp_addr / 14'(IMG_W);
      border_s    = (col_s == 14'd0) || (col_s == 14'(IMG_W - 1)) ||
                    (row_s == 14'd0) || (row_s == 14'(IMG_W - 1));
   end

   // Single-cycle read-modify-write value for the addressed bin (wrap or saturate)
   always_comb begin
      cur_s  = bins_r[lbp_data];
      full_s = (cur_s == {BIN_W{1'b1}});
      if (full_s) begin
`ifdef LBP_HIST_SAT_EN
         inc_s = cur_s;
`else
         inc_s = {BIN_W{1'b0}};
`endif
      end else begin
         inc_s = cur_s + {{(BIN_W-1){1'b0}}, 1'b1};
      end
   end

   // Next-state logic: finish starts the dump, the final handshake ends it
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ACCUM: begin
            if (finish) state_nxt_s = DUMP;
            else        state_nxt_s = ACCUM;
         end
         DUMP: begin
            if (last_s) state_nxt_s = ACCUM;
            else        state_nxt_s = DUMP;
         end
         default: state_nxt_s = ACCUM;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_r <= ACCUM;
      else       state_r <= state_nxt_s;
   end

   // Bin storage: increment on accepted sample, clear on read-out handshake
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) bins_r[i] <= {BIN_W{1'b0}};
      end else if (accept_s) begin
         bins_r[lbp_data] <= inc_s;
      end else if (handshake_s) begin
         bins_r[rd_idx_r] <= {BIN_W{1'b0}};
      end
   end

   // Output stream registers: load bin 0 on finish (including a same-cycle sample),
   // advance on each handshake so one bin moves per cycle with ready held high
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_idx_r     <= 8'd0;
         hist_count_r <= {BIN_W{1'b0}};
         hist_done_r  <= 1'b0;
      end else begin
         hist_done_r <= 1'b0;
         case (state_r)
            ACCUM: begin
               if (finish) begin
                  rd_idx_r     <= 8'd0;
                  hist_count_r <= (accept_s && (lbp_data == 8'd0)) ? inc_s : bins_r[0];
               end
            end
            DUMP: begin
               if (last_s) begin
                  rd_idx_r     <= 8'd0;
                  hist_count_r <= {BIN_W{1'b0}};
                  hist_done_r  <= 1'b1;
               end else if (handshake_s) begin
                  rd_idx_r     <= next_idx_s;
                  hist_count_r <= bins_r[next_idx_s];
               end
            end
            default: begin
               rd_idx_r     <= 8'd0;
               hist_count_r <= {BIN_W{1'b0}};
            end
         endcase
      end
   end

   // Saturating per-frame sample counter, cleared when the dump completes
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                pix_cnt_r <= 14'd0;
      else if (last_s)                          pix_cnt_r <= 14'd0;
      else if (accept_s && (pix_cnt_r != 14'h3FFF)) pix_cnt_r <= pix_cnt_r + 14'd1;
   end

   // Sticky error: border pixel, bin overflow, or sample arriving during dump
   always_ff @(posedge clk or posedge reset) begin
      if (reset) err_r <= 1'b0;
      else if ((accept_s && (border_s || full_s)) || ((state_r == DUMP) && lbp_valid))
         err_r <= 1'b1;
   end

   assign hist_valid = (state_r == DUMP);
   assign busy       = (state_r == DUMP);
   assign hist_bin   = rd_idx_r;
   assign hist_count = hist_count_r;
   assign hist_done  = hist_done_r;
   assign pix_cnt    = pix_cnt_r;
   assign err        = err_r;

endmodule

// File: tb/tb_lbp_hist.sv
// Self-checking bench for lbp_hist: directed and randomized frames against a
// bin-array reference model, plus a narrow-bin instance for overflow behaviour.
module tb_lbp_hist;

   logic        clk = 1'b0;
   logic        reset;
   logic        lbp_valid, finish, hist_ready;
   logic [13:0] lbp_addr;
   logic [7:0]  lbp_data;
   logic        hist_valid, hist_done, busy, err;
   logic [7:0]  hist_bin;
   logic [13:0] hist_count;
   logic [13:0] pix_cnt;

   logic        o_valid, o_finish, o_ready;
   logic [13:0] o_addr;
   logic [7:0]  o_data;
   logic        o_hvalid, o_done, o_busy, o_err;
   logic [7:0]  o_bin;
   logic [3:0]  o_count;
   logic [13:0] o_pix;

   int checks = 0;
   int errors = 0;
   int model [256];
   int exp_pix;
   bit exp_err;

   always #5 clk = ~clk;

   lbp_hist #(.BIN_W(14), .IMG_W(128)) dut (
      .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
      .lbp_data(lbp_data), .finish(finish), .hist_valid(hist_valid),
      .hist_ready(hist_ready), .hist_bin(hist_bin), .hist_count(hist_count),
      .hist_done(hist_done), .pix_cnt(pix_cnt), .busy(busy), .err(err));

   lbp_hist #(.BIN_W(4), .IMG_W(128)) u_ovf (
      .clk(clk), .reset(reset), .lbp_valid(o_valid), .lbp_addr(o_addr),
      .lbp_data(o_data), .finish(o_finish), .hist_valid(o_hvalid),
      .hist_ready(o_ready), .hist_bin(o_bin), .hist_count(o_count),
      .hist_done(o_done), .pix_cnt(o_pix), .busy(o_busy), .err(o_err));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: what one accepted sample does to the frame histogram
   task automatic acc(input int a, input int d);
      int row, col;
      row = a / 128;
      col = a % 128;
      if (row == 0 || row == 127 || col == 0 || col == 127) exp_err = 1'b1;
      model[d] = (model[d] + 1) % 16384;
      if (model[d] == 0) exp_err = 1'b1;
      if (exp_pix < 16383) exp_pix++;
   endtask

   task automatic pulse(input bit v, input int a, input int d, input bit f);
      lbp_valid = v;
      lbp_addr  = a[13:0];
      lbp_data  = d[7:0];
      finish    = f;
      if (v) acc(a, d);
      @(negedge clk);
      lbp_valid = 1'b0;
      finish    = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      lbp_valid = 1'b0; finish = 1'b0; hist_ready = 1'b0;
      lbp_addr = 14'd0; lbp_data = 8'd0;
      o_valid = 1'b0; o_finish = 1'b0; o_ready = 1'b0; o_addr = 14'd0; o_data = 8'd0;
      @(negedge clk);
      chk("rst_valid", hist_valid, 0);
      chk("rst_bin", hist_bin, 0);
      chk("rst_count", hist_count, 0);
      chk("rst_done", hist_done, 0);
      chk("rst_pix", pix_cnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 256; i++) model[i] = 0;
      exp_pix = 0;
      exp_err = 1'b0;
      @(negedge clk);
   endtask

   // Drain one dump; mode 0 = ready always, 1 = one-in-three, 2 = random
   task automatic dump(input int mode, input bit inject, output int sum);
      int idx;
      bit stalled;
      logic [7:0]  pb;
      logic [13:0] pc;
      sum = 0; idx = 0; stalled = 1'b0; pb = 8'd0; pc = 14'd0;
      chk("busy_start", busy, 1);
      chk("valid_start", hist_valid, 1);
      chk("pix_hold", pix_cnt, exp_pix);
      for (int cyc = 0; cyc < 2000 && idx < 256; cyc++) begin
         if (stalled) begin
            chk("stall_bin", hist_bin, pb);
            chk("stall_cnt", hist_count, pc);
         end
         hist_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 2) : 1'($urandom_range(0, 1));
         lbp_valid = inject && (cyc == 4);
         lbp_addr  = 14'd300;
         lbp_data  = 8'd9;
         if (lbp_valid) exp_err = 1'b1;
         finish = (cyc == 6);
         if (hist_ready) begin
            chk("dump_bin", hist_bin, idx);
            chk("dump_cnt", hist_count, model[idx]);
            sum += int'(hist_count);
            model[idx] = 0;
            idx++;
            stalled = 1'b0;
         end else begin
            pb = hist_bin;
            pc = hist_count;
            stalled = 1'b1;
         end
         @(negedge clk);
         lbp_valid = 1'b0;
         finish = 1'b0;
         if (idx < 256) begin
            chk("valid_mid", hist_valid, 1);
            chk("done_early", hist_done, 0);
         end
      end
      hist_ready = 1'b0;
      chk("dump_len", idx, 256);
      chk("done_pulse", hist_done, 1);
      chk("valid_end", hist_valid, 0);
      chk("busy_end", busy, 0);
      chk("pix_clr", pix_cnt, 0);
      exp_pix = 0;
      @(negedge clk);
      chk("done_once", hist_done, 0);
   endtask

   initial begin
      int sum, n, a;
      int exp_ovf;
      reset = 1'b1;
      do_reset();

      // Overflow on the 4-bit-bin instance: 20 samples of code 7
`ifdef LBP_HIST_SAT_EN
      exp_ovf = 15;
`else
      exp_ovf = 4;
`endif
      o_addr = 14'd129; o_data = 8'd7; o_valid = 1'b1;
      repeat (20) @(negedge clk);
      o_valid = 1'b0; o_finish = 1'b1;
      @(negedge clk);
      o_finish = 1'b0;
      chk("ovf_bin0", o_bin, 0);
      o_ready = 1'b1;
      repeat (7) @(negedge clk);
      chk("ovf_bin", o_bin, 7);
      chk("ovf_cnt", o_count, exp_ovf);
      repeat (249) @(negedge clk);
      o_ready = 1'b0;
      chk("ovf_done", o_done, 1);
      chk("ovf_err", o_err, 1);

      // Single sample
      pulse(1'b1, 129, 8'h5A, 1'b0);
      chk("single_pix", pix_cnt, 1);
      pulse(1'b0, 0, 0, 1'b1);
      dump(0, 1'b0, sum);
      chk("single_sum", sum, 1);
      chk("single_err", err, exp_err);

      // Back-to-back same bin, finish together with the 5th sample
      for (int i = 0; i < 5; i++) pulse(1'b1, 130 + i, 8'hFF, i == 4);
      dump(0, 1'b0, sum);
      chk("b2b_sum", sum, 5);

      // Random frame under one-in-three backpressure
      n = $urandom_range(200, 600);
      for (int i = 0; i < n; i++) begin
         a = $urandom_range(1, 126) * 128 + $urandom_range(1, 126);
         pulse(1'b1, a, $urandom_range(0, 255), i == n - 1);
      end
      dump(1, 1'b0, sum);
      chk("bp_sum", sum, n);
      chk("bp_err", err, exp_err);

      // Border sample, then a sample during dump (dropped, sets err)
      pulse(1'b1, 0, 3, 1'b0);
      chk("border_err", err, 1);
      pulse(1'b0, 0, 0, 1'b1);
      dump(2, 1'b1, sum);
      chk("border_sum", sum, 1);
      pulse(1'b0, 0, 0, 1'b1);
      dump(0, 1'b0, sum);
      chk("dropped_sum", sum, 0);
      chk("err_sticky", err, 1);

      // Full frame twice, data = addr[7:0]
      for (int f = 0; f < 2; f++) begin
         for (int r = 1; r < 127; r++)
            for (int c = 1; c < 127; c++)
               pulse(1'b1, r * 128 + c, (r * 128 + c) % 256, 1'b0);
         chk("full_pix", pix_cnt, 15876);
         pulse(1'b0, 0, 0, 1'b1);
         dump(0, 1'b0, sum);
         chk("full_sum", sum, 15876);
      end

      // Reset in the middle of a dump abandons the frame
      for (int i = 0; i < 20; i++) pulse(1'b1, 200 + i, $urandom_range(0, 255), i == 19);
      hist_ready = 1'b1;
      repeat (10) @(negedge clk);
      do_reset();
      pulse(1'b0, 0, 0, 1'b1);
      dump(2, 1'b0, sum);
      chk("rstmid_sum", sum, 0);

      // Random frame with random ready, finish separate
      n = $urandom_range(50, 300);
      for (int i = 0; i < n; i++) begin
         a = $urandom_range(1, 126) * 128 + $urandom_range(1, 126);
         pulse(1'b1, a, $urandom_range(0, 15), 1'b0);
      end
      pulse(1'b0, 0, 0, 1'b1);
      dump(2, 1'b0, sum);
      chk("rand_sum", sum, n);
      chk("rand_err", err, exp_err);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lbp_hist.md
# lbp_hist

Downstream consumer of the LBP engine's output stream. Accumulates a 256-bin histogram of LBP codes for one 128×128 frame, with 126×126 = 15876 interior pixels. On the engine's `finish` pulse, it streams the bins out in order (bin 0..255) over a valid/ready interface. Each bin is cleared as it is read, so the block is ready for the next frame without a separate clear pass.

## Interface

Parameters:
- `BIN_W`, default 14: bin counter width. 14 covers 15876.
- `IMG_W`, default 128: image width/height in pixels. Used for the border check.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high.
- `lbp_valid`, in, 1: one-cycle strobe; `lbp_addr`/`lbp_data` valid.
- `lbp_addr`, in, 14: pixel address, row-major, `IMG_W` per row.
- `lbp_data`, in, 8: LBP code, selects the bin.
- `finish`, in, 1: one-cycle pulse; the frame is complete.
- `hist_valid`, out, 1: `hist_bin`/`hist_count` valid.
- `hist_ready`, in, 1: sink accepts the current bin.
- `hist_bin`, out, 8: bin index being output.
- `hist_count`, out, `BIN_W`: count for `hist_bin`.
- `hist_done`, out, 1: one-cycle pulse after bin 255 is accepted.
- `pix_cnt`, out, 14: samples accepted in the current frame.
- `busy`, out, 1: high in DUMP.
- `err`, out, 1: sticky error flag; cleared only by reset.

## Operation

- Storage: 256 × `BIN_W` register array, asynchronously reset to 0.
- States: `ACCUM` (reset state) and `DUMP`.
- **ACCUM**
  - On `lbp_valid`, `bin[lbp_data]` increments and `pix_cnt` increments.
  - Back-to-back strobes to the same bin must each count: single-cycle read-modify-write with no pipeline hazard.
  - On `finish`, go to `DUMP` and load `rd_idx = 0`.
- **Simultaneous `lbp_valid` and `finish`:** the sample is counted first. The DUMP output of that bin must include it.
- **Border check:** `lbp_valid` with column 0 or `IMG_W-1`, or row 0 or `IMG_W-1`, sets `err`. The sample is still counted.
- **DUMP**
  - `hist_valid = 1`, `hist_bin = rd_idx`, `hist_count = bin[rd_idx]`.
  - On `hist_valid && hist_ready`: `bin[rd_idx] <= 0` and `rd_idx` increments.
  - When `rd_idx == 255` is accepted: pulse `hist_done`, clear `pix_cnt` to 0, return to `ACCUM`.
- **`lbp_valid` during DUMP:** the sample is dropped, `err` is set, and `pix_cnt` is unchanged.
- **`finish` during DUMP:** ignored. No error.
- **Overflow:** a bin at `2^BIN_W − 1` that increments wraps to 0 and sets `err`. Behaviour under `LBP_HIST_SAT_EN` is given in Configuration.
- **`pix_cnt`:** saturates at 16383 and never wraps.
- **Reset mid-DUMP:** all bins, `rd_idx` and `pix_cnt` go to 0; the state returns to `ACCUM`; partial output is abandoned.

## Timing

- Reset values: `hist_valid = 0`, `hist_bin = 0`, `hist_count = 0`, `hist_done = 0`, `pix_cnt = 0`, `busy = 0`, `err = 0`.
- **Accumulate latency:**
  - A strobe at edge N is reflected in the bin and `pix_cnt` after edge N.
  - A read in the following cycle returns the updated value.
- **Dump start:** `finish` sampled at edge N gives `hist_valid = 1` and `busy = 1` from edge N+1, bin 0 first.
- **Output registering:** `hist_bin`/`hist_count` are registered. They must update within the same edge as the handshake, so that with `hist_ready` held high one bin is transferred per cycle.
- **Dump length:** 256 cycles minimum.
- **Stall rule:** while `hist_valid && !hist_ready`, `hist_bin` and `hist_count` hold stable.
- **`hist_done`:** asserts the cycle after the final handshake. In that same cycle `hist_valid = 0` and `busy = 0`.
- **Re-acceptance:** a sample is accepted again from that cycle onward.

## Configuration

- `LBP_HIST_SAT_EN` defined:
  - bins saturate at `2^BIN_W − 1`;
  - further increments hold the value and set `err`.
- Undefined: bins wrap modulo `2^BIN_W`, and the wrap sets `err`.
- All other behaviour is identical in both builds.

## Test plan

- **Single sample:** reset; one strobe `addr = 129`, `data = 0x5A`; then `finish`.
  - Required: bin 0x5A = 1, all other bins 0, `hist_done` after 256 handshakes, `err = 0`.
- **Back-to-back same code:** 5 consecutive-cycle strobes with `data = 0xFF`, interior addresses, plus a simultaneous `finish` on the 5th.
  - Required: bin 255 = 5, `pix_cnt = 5` before `hist_done`.
- **Full frame:** drive all 15876 interior addresses with `data = addr[7:0]`.
  - Required: the sum of `hist_count` = 15876, each bin matches the reference model.
  - Required: a second identical frame gives identical results (clear-on-read verified).
- **Backpressure:** toggle `hist_ready` with a 1-in-3 duty during DUMP.
  - Required: no bin skipped or duplicated, values stable while stalled, 256 handshakes.
- **Error cases:** `lbp_addr = 0` (border) with `data = 3`, then a strobe during DUMP.
  - Required: `err = 1` sticky; bin 3 = 1; the DUMP-time sample absent from the next frame.
- **Overflow:** `BIN_W = 4`, 20 strobes with `data = 7`.
  - Required: bin 7 = 15 with `LBP_HIST_SAT_EN`, 4 without; `err = 1` in both builds.
